// File: rtl/avm_master_pkg.sv
// Shared types and default sizes for the Avalon-MM PIO master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package avm_master_pkg;

    localparam int AVM_ADDR_W      = 4;
    localparam int AVM_DATA_W      = 32;
    localparam int AVM_FIFO_DEPTH  = 4;
    localparam int AVM_TIMEOUT_CYC = 255;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Command as queued at the default widths; the top re-declares the same
    // shape at its own parameterised widths and hands it to the FIFO.
    typedef struct packed {
        logic                  write;
        logic [AVM_ADDR_W-1:0] addr;
        logic [AVM_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/avm_pio_master_if.sv
// Requester command/response channel plus Avalon-MM master bus, as one bundle.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready on the command side; responses are not backpressured.
// Modports: master = the avm_pio_master side, slave = requester + Avalon slave side.
interface avm_pio_master_if #(
    parameter int ADDR_W = avm_master_pkg::AVM_ADDR_W,
    parameter int DATA_W = avm_master_pkg::AVM_DATA_W
);
    // requester command
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    // requester response
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // Avalon-MM master bus
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic              avm_read_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  avm_readdata, avm_waitrequest,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output avm_readdata, avm_waitrequest,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );
endinterface

// File: rtl/avm_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of type T, storage and pointers in flops.
// Latency: a push is visible at head_dat/!empty the cycle after it is written.
// Backpressure: full blocks pushes (no pass-through); pops on empty are ignored.
// Ports: clk, reset_n (async flush), push_vld/push_dat, pop_rdy, head_dat, full, empty.
module avm_cmd_fifo
    import avm_master_pkg::*;
#(
    parameter type T     = cmd_t,
    parameter int  DEPTH = AVM_FIFO_DEPTH   // power of 2, >= 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_vld,
    input  T     push_dat,
    input  logic pop_rdy,
    output T     head_dat,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    T               mem_q [DEPTH];
    T               mem_d [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_rdy & ~empty;
    assign head_dat = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_dat;
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/avm_pio_master.sv
// Avalon-MM master issuing queued register read/write commands, one response per command in order.
// Latency: handshake at N -> bus active N+2 -> rsp_valid N+3 with zero wait states; max 1 txn / 2 cycles.
// Backpressure: cmd_ready = FIFO not full; bus stalls on avm_waitrequest; responses are never stalled.
// Ports: clk, reset_n (async, active-low), bus (avm_pio_master_if.master: cmd_*, rsp_*, avm_*).
// Build option AVM_TIMEOUT_EN: abort a transaction after TIMEOUT_CYC waitrequest cycles (rsp_err=1).
module avm_pio_master
    import avm_master_pkg::*;
#(
    parameter int ADDR_W      = AVM_ADDR_W,
    parameter int DATA_W      = AVM_DATA_W,
    parameter int FIFO_DEPTH  = AVM_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = AVM_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             reset_n,
    avm_pio_master_if.master bus
);
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_w_t;

    cmd_w_t push_dat;
    cmd_w_t head_dat;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   cmd_rdy;

    state_e            state_q,     state_d;
    logic              rdy_en_q,    rdy_en_d;
    logic              cs_q,        cs_d;
    logic              write_n_q,   write_n_d;
    logic              read_n_q,    read_n_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              rsp_vld_q,   rsp_vld_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

`ifdef AVM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    // TIMEOUT_CYC only matters in the timeout build.
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    // rdy_en_q holds cmd_ready low until the first edge after reset release.
    assign cmd_rdy  = rdy_en_q & ~fifo_full;
    assign push_dat = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

    avm_cmd_fifo #(
        .T     (cmd_w_t),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (bus.cmd_valid & cmd_rdy),
        .push_dat (push_dat),
        .pop_rdy  (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        rdy_en_d    = 1'b1;
        cs_d        = cs_q;
        write_n_d   = write_n_q;
        read_n_d    = read_n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_vld_d   = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        pop         = 1'b0;
`ifdef AVM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Entering ISSUE only from IDLE guarantees one idle bus cycle
                // between consecutive transactions.
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    cs_d      = 1'b1;
                    write_n_d = ~head_dat.write;
                    read_n_d  = head_dat.write;
                    addr_d    = head_dat.addr;
                    wdata_d   = head_dat.wdata;
                    state_d   = ISSUE;
`ifdef AVM_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ISSUE: begin
                if (!bus.avm_waitrequest) begin
                    cs_d        = 1'b0;
                    write_n_d   = 1'b1;
                    read_n_d    = 1'b1;
                    rsp_vld_d   = 1'b1;
                    rsp_rdata_d = read_n_q ? '0 : bus.avm_readdata;
                    state_d     = IDLE;
                end
`ifdef AVM_TIMEOUT_EN
                // tmo_cnt_q counts earlier stalls; this stall would be number
                // TIMEOUT_CYC, so give up now.
                else if (tmo_cnt_q == TMO_LAST) begin
                    cs_d      = 1'b0;
                    write_n_d = 1'b1;
                    read_n_d  = 1'b1;
                    rsp_vld_d = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes come straight from async-reset flops so a reset drops them immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rdy_en_q    <= 1'b0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            read_n_q    <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef AVM_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= rdy_en_d;
            cs_q        <= cs_d;
            write_n_q   <= write_n_d;
            read_n_q    <= read_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef AVM_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign bus.cmd_ready      = cmd_rdy;
    assign bus.rsp_valid      = rsp_vld_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = cs_q;
    assign bus.avm_write_n    = write_n_q;
    assign bus.avm_read_n     = read_n_q;
    assign bus.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_avm_pio_master.sv
// Bench for avm_pio_master: directed commands, a PIO register slave model and an in-order response scoreboard.
// Latency: n/a.
// Backpressure: the slave model stalls through a bench-controlled waitrequest.
module tb_avm_pio_master;
    import avm_master_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic clk;
    logic reset_n;

    avm_pio_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    avm_pio_master #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO-style slave: register file written on accepted writes, read combinationally.
    logic [DW-1:0] mem [16];
    logic          rd_force;
    logic [DW-1:0] rd_force_val;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest) begin
            mem[bus.avm_address] <= bus.avm_writedata;
        end
    end
    assign bus.avm_readdata = rd_force ? rd_force_val : mem[bus.avm_address];

    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    // Bus-model state used by the monitor.
    logic        end_prev;
    logic        stall_prev;
    int          stall_cnt;
    int          run_cnt;
    int          last_run_len;
    logic [38:0] snap;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic monitor();
        logic        end_now;
        logic        stall_now;
        logic [38:0] cur;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                end_prev   = 1'b0;
                stall_prev = 1'b0;
                stall_cnt  = 0;
                run_cnt    = 0;
            end else begin
                cur = {bus.avm_address, bus.avm_writedata, bus.avm_write_n,
                       bus.avm_read_n, bus.avm_chipselect};
                if (bus.rsp_valid || end_prev) check("rsp_timing", bus.rsp_valid, end_prev);
                if (end_prev) check("idle_gap", bus.avm_chipselect, 0);
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", bus.rsp_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", bus.rsp_rdata, e.rdata);
                        check("rsp_err", bus.rsp_err, e.err);
                    end
                end
                if (stall_prev) check("stall_stable", cur, snap);
                if (bus.avm_chipselect) check("one_strobe", bus.avm_write_n ^ bus.avm_read_n, 1);

                end_now   = 1'b0;
                stall_now = 1'b0;
                if (bus.avm_chipselect) begin
                    run_cnt++;
                    if (!bus.avm_waitrequest) begin
                        end_now = 1'b1;
`ifdef AVM_TIMEOUT_EN
                    end else if (stall_cnt == TMO - 1) begin
                        end_now = 1'b1;
`endif
                    end else begin
                        stall_now = 1'b1;
                        stall_cnt++;
                    end
                end else begin
                    stall_cnt = 0;
                    if (run_cnt != 0) begin
                        last_run_len = run_cnt;
                        run_cnt      = 0;
                    end
                end
                snap       = cur;
                end_prev   = end_now;
                stall_prev = stall_now;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd, input logic exp_err);
        int   n;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_accept", bus.cmd_ready, 1);
        if (bus.cmd_ready) begin
            @(posedge clk);
            e.rdata = exp_rd;
            e.err   = exp_err;
            exp_q.push_back(e);
            #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.avm_chipselect) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, exp_q.size(), 0);
    endtask

    initial begin
        int cs_seen;
        int n;
        n_checks        = 0;
        n_fail          = 0;
        end_prev        = 1'b0;
        stall_prev      = 1'b0;
        stall_cnt       = 0;
        run_cnt         = 0;
        last_run_len    = 0;
        snap            = '0;
        rd_force        = 1'b0;
        rd_force_val    = '0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_wdata   = '0;
        bus.avm_waitrequest = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        fork
            monitor();
        join_none

        // Reset values
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_cs", bus.avm_chipselect, 0);
        check("rst_write_n", bus.avm_write_n, 1);
        check("rst_read_n", bus.avm_read_n, 1);
        check("rst_address", bus.avm_address, 0);
        check("rst_writedata", bus.avm_writedata, 0);
        #20 reset_n = 1'b1;               // t=22, between edges
        #1 check("rdy_before_edge", bus.cmd_ready, 0);
        @(posedge clk); #1;
        check("rdy_after_edge", bus.cmd_ready, 1);

        // 1: single write, zero wait states, exact latency
        send(1'b1, 4'h0, 32'h3, 32'h0, 1'b0);
        @(negedge clk); check("t1_n1_cs", bus.avm_chipselect, 0);
        @(negedge clk);
        check("t1_n2_cs", bus.avm_chipselect, 1);
        check("t1_n2_write_n", bus.avm_write_n, 0);
        check("t1_n2_read_n", bus.avm_read_n, 1);
        check("t1_n2_wdata", bus.avm_writedata, 32'h3);
        check("t1_n2_addr", bus.avm_address, 0);
        @(negedge clk);
        check("t1_n3_rsp_valid", bus.rsp_valid, 1);
        check("t1_n3_cs", bus.avm_chipselect, 0);
        @(posedge clk); #1;
        drain("t1_drain");
        check("t1_run_len", last_run_len, 1);
        check("t1_mem0", mem[0], 32'h3);

        // 2: read with 3 waitrequest cycles, slave returns 0x2
        rd_force     = 1'b1;
        rd_force_val = 32'h2;
        bus.avm_waitrequest = 1'b1;
        send(1'b0, 4'h0, 32'h0, 32'h2, 1'b0);
        repeat (4) @(posedge clk);
        #1 bus.avm_waitrequest = 1'b0;
        drain("t2_drain");
        check("t2_run_len", last_run_len, 4);
        rd_force = 1'b0;

        // 3: five back-to-back commands while stalled; FIFO fills behind the one in flight
        bus.avm_waitrequest = 1'b1;
        send(1'b1, 4'h1, 32'h11, 32'h0, 1'b0);
        send(1'b0, 4'h1, 32'h0, 32'h11, 1'b0);
        send(1'b1, 4'h2, 32'h22, 32'h0, 1'b0);
        send(1'b0, 4'h2, 32'h0, 32'h22, 1'b0);
        send(1'b0, 4'h1, 32'h0, 32'h11, 1'b0);
        check("t3_ready_full", bus.cmd_ready, 0);
        repeat (3) @(posedge clk);
        #1 check("t3_ready_held", bus.cmd_ready, 0);
        bus.avm_waitrequest = 1'b0;
        drain("t3_drain");

        // 4: write 1 / read / write 2 on addr 0, zero wait states
        send(1'b1, 4'h0, 32'h1, 32'h0, 1'b0);
        send(1'b0, 4'h0, 32'h0, 32'h1, 1'b0);
        send(1'b1, 4'h0, 32'h2, 32'h0, 1'b0);
        drain("t4_drain");
        check("t4_mem0", mem[0], 32'h2);

        // 5: reset in the middle of a stalled transaction with two more queued
        bus.avm_waitrequest = 1'b1;
        send(1'b1, 4'h6, 32'h66, 32'h0, 1'b0);
        send(1'b1, 4'h7, 32'h77, 32'h0, 1'b0);
        send(1'b1, 4'h8, 32'h88, 32'h0, 1'b0);
        n = 0;
        while (!bus.avm_chipselect && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_cs_active", bus.avm_chipselect, 1);
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_cs_async", bus.avm_chipselect, 0);
        check("t5_write_n_async", bus.avm_write_n, 1);
        check("t5_read_n_async", bus.avm_read_n, 1);
        check("t5_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk); @(posedge clk);
        #3 reset_n = 1'b1;
        #1 check("t5_rdy_before_edge", bus.cmd_ready, 0);
        bus.avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        check("t5_rdy_after_edge", bus.cmd_ready, 1);
        cs_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.avm_chipselect) cs_seen++;
        end
        check("t5_fifo_flushed", cs_seen, 0);
        @(posedge clk); #1;
        send(1'b1, 4'h3, 32'h5A, 32'h0, 1'b0);
        send(1'b0, 4'h3, 32'h0, 32'h5A, 1'b0);
        drain("t5_drain");

`ifdef AVM_TIMEOUT_EN
        // 6: stuck waitrequest aborts after TMO stalls; the next command still completes
        bus.avm_waitrequest = 1'b1;
        send(1'b1, 4'h4, 32'h44, 32'h0, 1'b1);
        send(1'b1, 4'h5, 32'h55, 32'h0, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_abort_seen", bus.rsp_valid, 1);
        bus.avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        check("t6_run_len", last_run_len, TMO);
        drain("t6_drain");
        check("t6_mem4", mem[4], 32'h0);
        check("t6_mem5", mem[5], 32'h55);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
